// File: rtl/pe_cache_responder_pkg.sv
// Shared widths, FSM state encoding and cache line payload for the PE cache responder.
package pe_cache_responder_pkg;

    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned ADDR_WIDTH  = 16;
    localparam int unsigned INDEX_WIDTH = 6;
    localparam int unsigned TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH;
    localparam int unsigned NUM_LINES   = 2 ** INDEX_WIDTH;

    typedef enum logic [1:0] {
        CR_IDLE    = 2'd0,
        CR_RD_MISS = 2'd1,
        CR_WR_THRU = 2'd2,
        CR_FLUSH   = 2'd3
    } cr_state_e;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } line_t;

endpackage

// File: rtl/pe_cache_line_array.sv
// Direct-mapped tag+data storage (one write port, async read, no reset) plus valid-bit flops.
module pe_cache_line_array
    import pe_cache_responder_pkg::*;
(
    input  logic                   clk,
    input  logic                   clear_all,
    input  logic                   clear_one,
    input  logic [INDEX_WIDTH-1:0] clear_idx,
    input  logic                   set_one,
    input  logic                   we,
    input  logic [INDEX_WIDTH-1:0] widx,
    input  line_t                  wline,
    input  logic [INDEX_WIDTH-1:0] ridx,
    output line_t                  rline,
    output logic                   rvalid
);

    line_t                mem [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wline;
        end
    end

    // clear-all wins over the per-line ports; set-one targets the write index
    always_ff @(posedge clk) begin
        if (clear_all) begin
            valid_q <= '0;
        end else begin
            if (clear_one) begin
                valid_q[clear_idx] <= 1'b0;
            end
            if (set_one) begin
                valid_q[widx] <= 1'b1;
            end
        end
    end

    assign rline  = mem[ridx];
    assign rvalid = valid_q[ridx];

endmodule

// File: rtl/pe_cache_responder.sv
// Write-through direct-mapped cache responder for one memory-access PE with req/ack backing memory.
module pe_cache_responder
    import pe_cache_responder_pkg::*;
(
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  PE_VALID_I,
    input  logic                  PE_WR_I,
    input  logic [ADDR_WIDTH-1:0] PE_BASE_I,
    input  logic [DATA_WIDTH-1:0] PE_OFFSET_I,
    input  logic [DATA_WIDTH-1:0] PE_WDATA_I,
    output logic [DATA_WIDTH-1:0] PE_DATA_O,
    output logic                  STALL_O,
    input  logic                  FLUSH_I,
    output logic                  MEM_REQ_O,
    output logic                  MEM_WR_O,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR_O,
    output logic [DATA_WIDTH-1:0] MEM_WDATA_O,
    input  logic                  MEM_ACK_I,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA_I
);

    cr_state_e              state_q, state_d;
    logic [INDEX_WIDTH-1:0] flush_cnt_q;
    logic                   flush_pend_q;

    logic [ADDR_WIDTH-1:0]  eff_addr;
    logic [INDEX_WIDTH-1:0] index;
    logic [TAG_WIDTH-1:0]   tag;
    line_t                  rline;
    logic                   rvalid;
    logic                   hit;
    logic                   idle;

    logic accept_rd_hit, accept_rd_miss, accept_wr, fill, wr_done, flush_step, start_flush;

    assign eff_addr = PE_BASE_I + PE_OFFSET_I[ADDR_WIDTH-1:0];
    assign index    = eff_addr[INDEX_WIDTH-1:0];
    assign tag      = eff_addr[ADDR_WIDTH-1:INDEX_WIDTH];
    assign hit      = rvalid && (rline.tag == tag);
    assign idle     = (state_q == CR_IDLE);

    assign STALL_O = !idle
                   | (PE_VALID_I & (PE_WR_I | !hit))
                   | FLUSH_I | flush_pend_q;

    // Fills use the registered miss address; write hits update the line at acceptance.
    pe_cache_line_array u_lines (
        .clk       (CLK_I),
        .clear_all (RST_I),
        .clear_one (flush_step),
        .clear_idx (flush_cnt_q),
        .set_one   (fill),
        .we        (fill | (accept_wr & hit)),
        .widx      (fill ? MEM_ADDR_O[INDEX_WIDTH-1:0] : index),
        .wline     (fill ? line_t'{tag: MEM_ADDR_O[ADDR_WIDTH-1:INDEX_WIDTH], data: MEM_RDATA_I}
                         : line_t'{tag: tag, data: PE_WDATA_I}),
        .ridx      (index),
        .rline     (rline),
        .rvalid    (rvalid)
    );

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= CR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pending or fresh flush takes priority over a PE request in IDLE.
    always_comb begin
        state_d        = state_q;
        accept_rd_hit  = 1'b0;
        accept_rd_miss = 1'b0;
        accept_wr      = 1'b0;
        fill           = 1'b0;
        wr_done        = 1'b0;
        flush_step     = 1'b0;
        start_flush    = 1'b0;
        case (state_q)
            CR_IDLE: begin
                if (FLUSH_I || flush_pend_q) begin
                    state_d     = CR_FLUSH;
                    start_flush = 1'b1;
                end else if (PE_VALID_I) begin
                    if (PE_WR_I) begin
                        state_d   = CR_WR_THRU;
                        accept_wr = 1'b1;
                    end else if (hit) begin
                        accept_rd_hit = 1'b1;
                    end else begin
                        state_d        = CR_RD_MISS;
                        accept_rd_miss = 1'b1;
                    end
                end
            end
            CR_RD_MISS: begin
                if (MEM_ACK_I) begin
                    fill    = 1'b1;
                    state_d = CR_IDLE;
                end
            end
            CR_WR_THRU: begin
                if (MEM_ACK_I) begin
                    wr_done = 1'b1;
                    state_d = CR_IDLE;
                end
            end
            CR_FLUSH: begin
                flush_step = 1'b1;
                if (flush_cnt_q == INDEX_WIDTH'(NUM_LINES - 1)) begin
                    state_d = CR_IDLE;
                end
            end
            default: state_d = CR_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            PE_DATA_O    <= '0;
            MEM_REQ_O    <= 1'b0;
            MEM_WR_O     <= 1'b0;
            MEM_ADDR_O   <= '0;
            MEM_WDATA_O  <= '0;
            flush_cnt_q  <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            if (accept_rd_miss || accept_wr) begin
                MEM_REQ_O  <= 1'b1;
                MEM_WR_O   <= accept_wr;
                MEM_ADDR_O <= eff_addr;
                if (accept_wr) begin
                    MEM_WDATA_O <= PE_WDATA_I;
                end
            end else if (fill || wr_done) begin
                MEM_REQ_O <= 1'b0;
                MEM_WR_O  <= 1'b0;
            end

            if (accept_rd_hit) begin
                PE_DATA_O <= rline.data;
            end else if (fill) begin
                PE_DATA_O <= MEM_RDATA_I;
            end

            if (flush_step) begin
                flush_cnt_q <= flush_cnt_q + INDEX_WIDTH'(1);
            end

            // A flush requested while a memory transaction is open waits for IDLE.
            if (start_flush) begin
                flush_pend_q <= 1'b0;
            end else if (FLUSH_I && (state_q == CR_RD_MISS || state_q == CR_WR_THRU)) begin
                flush_pend_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pe_cache_responder.sv
// Directed self-checking bench for pe_cache_responder; the bench itself plays backing memory.
module tb_pe_cache_responder;

    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic        PE_VALID_I;
    logic        PE_WR_I;
    logic [15:0] PE_BASE_I;
    logic [31:0] PE_OFFSET_I;
    logic [31:0] PE_WDATA_I;
    logic [31:0] PE_DATA_O;
    logic        STALL_O;
    logic        FLUSH_I;
    logic        MEM_REQ_O;
    logic        MEM_WR_O;
    logic [15:0] MEM_ADDR_O;
    logic [31:0] MEM_WDATA_O;
    logic        MEM_ACK_I;
    logic [31:0] MEM_RDATA_I;

    int checks   = 0;
    int failures = 0;

    pe_cache_responder dut (
        .CLK_I       (CLK_I),
        .RST_I       (RST_I),
        .PE_VALID_I  (PE_VALID_I),
        .PE_WR_I     (PE_WR_I),
        .PE_BASE_I   (PE_BASE_I),
        .PE_OFFSET_I (PE_OFFSET_I),
        .PE_WDATA_I  (PE_WDATA_I),
        .PE_DATA_O   (PE_DATA_O),
        .STALL_O     (STALL_O),
        .FLUSH_I     (FLUSH_I),
        .MEM_REQ_O   (MEM_REQ_O),
        .MEM_WR_O    (MEM_WR_O),
        .MEM_ADDR_O  (MEM_ADDR_O),
        .MEM_WDATA_O (MEM_WDATA_O),
        .MEM_ACK_I   (MEM_ACK_I),
        .MEM_RDATA_I (MEM_RDATA_I)
    );

    always #5 CLK_I = ~CLK_I;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    // Read that must miss: checks stall, request fields, hold, then acks with rdata.
    task automatic read_miss(input logic [15:0] base, input logic [31:0] off,
                             input logic [15:0] exp_addr, input logic [31:0] rdata);
        PE_VALID_I = 1'b1; PE_WR_I = 1'b0; PE_BASE_I = base; PE_OFFSET_I = off;
        #1;
        checks++; if (STALL_O !== 1'b1) begin failures++; $display("FAIL rm_stall_accept got=%0b exp=1", STALL_O); end
        tick();
        checks++; if (MEM_REQ_O !== 1'b1) begin failures++; $display("FAIL rm_req got=%0b exp=1", MEM_REQ_O); end
        checks++; if (MEM_WR_O !== 1'b0) begin failures++; $display("FAIL rm_wr got=%0b exp=0", MEM_WR_O); end
        checks++; if (MEM_ADDR_O !== exp_addr) begin failures++; $display("FAIL rm_addr got=%h exp=%h", MEM_ADDR_O, exp_addr); end
        checks++; if (STALL_O !== 1'b1) begin failures++; $display("FAIL rm_stall_busy got=%0b exp=1", STALL_O); end
        tick();
        checks++; if (MEM_REQ_O !== 1'b1 || MEM_ADDR_O !== exp_addr) begin failures++; $display("FAIL rm_hold req=%0b addr=%h exp=1/%h", MEM_REQ_O, MEM_ADDR_O, exp_addr); end
        MEM_ACK_I = 1'b1; MEM_RDATA_I = rdata;
        tick();
        MEM_ACK_I = 1'b0; MEM_RDATA_I = '0;
        checks++; if (PE_DATA_O !== rdata) begin failures++; $display("FAIL rm_data got=%h exp=%h", PE_DATA_O, rdata); end
        checks++; if (MEM_REQ_O !== 1'b0) begin failures++; $display("FAIL rm_req_drop got=%0b exp=0", MEM_REQ_O); end
        checks++; if (STALL_O !== 1'b0) begin failures++; $display("FAIL rm_stall_done got=%0b exp=0", STALL_O); end
        PE_VALID_I = 1'b0;
    endtask

    task automatic read_hit(input logic [15:0] addr, input logic [31:0] exp_data);
        PE_VALID_I = 1'b1; PE_WR_I = 1'b0; PE_BASE_I = addr; PE_OFFSET_I = '0;
        #1;
        checks++; if (STALL_O !== 1'b0) begin failures++; $display("FAIL rh_stall got=%0b exp=0", STALL_O); end
        tick();
        PE_VALID_I = 1'b0;
        checks++; if (PE_DATA_O !== exp_data) begin failures++; $display("FAIL rh_data got=%h exp=%h", PE_DATA_O, exp_data); end
        checks++; if (MEM_REQ_O !== 1'b0) begin failures++; $display("FAIL rh_no_req got=%0b exp=0", MEM_REQ_O); end
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input logic [31:0] exp_pe);
        PE_VALID_I = 1'b1; PE_WR_I = 1'b1; PE_BASE_I = addr; PE_OFFSET_I = '0; PE_WDATA_I = data;
        #1;
        checks++; if (STALL_O !== 1'b1) begin failures++; $display("FAIL wr_stall got=%0b exp=1", STALL_O); end
        tick();
        checks++; if (MEM_REQ_O !== 1'b1 || MEM_WR_O !== 1'b1) begin failures++; $display("FAIL wr_req req=%0b wr=%0b exp=1/1", MEM_REQ_O, MEM_WR_O); end
        checks++; if (MEM_ADDR_O !== addr || MEM_WDATA_O !== data) begin failures++; $display("FAIL wr_fields addr=%h data=%h exp=%h/%h", MEM_ADDR_O, MEM_WDATA_O, addr, data); end
        tick();
        checks++; if (MEM_REQ_O !== 1'b1 || MEM_WDATA_O !== data) begin failures++; $display("FAIL wr_hold req=%0b data=%h exp=1/%h", MEM_REQ_O, MEM_WDATA_O, data); end
        MEM_ACK_I = 1'b1;
        tick();
        MEM_ACK_I = 1'b0; PE_VALID_I = 1'b0; PE_WR_I = 1'b0;
        #1;
        checks++; if (MEM_REQ_O !== 1'b0 || STALL_O !== 1'b0) begin failures++; $display("FAIL wr_done req=%0b stall=%0b exp=0/0", MEM_REQ_O, STALL_O); end
        checks++; if (PE_DATA_O !== exp_pe) begin failures++; $display("FAIL wr_pe_data got=%h exp=%h", PE_DATA_O, exp_pe); end
    endtask

    task automatic test_reset();
        checks++; if (PE_DATA_O !== 32'h0) begin failures++; $display("FAIL reset_pe_data got=%h exp=0", PE_DATA_O); end
        checks++; if (MEM_REQ_O !== 1'b0 || MEM_WR_O !== 1'b0) begin failures++; $display("FAIL reset_req req=%0b wr=%0b exp=0/0", MEM_REQ_O, MEM_WR_O); end
        checks++; if (MEM_ADDR_O !== 16'h0 || MEM_WDATA_O !== 32'h0) begin failures++; $display("FAIL reset_bus addr=%h data=%h exp=0/0", MEM_ADDR_O, MEM_WDATA_O); end
        checks++; if (STALL_O !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", STALL_O); end
    endtask

    task automatic test_read_miss();
        read_miss(16'h0010, 32'h5, 16'h0015, 32'hCAFE0001);
    endtask

    task automatic test_read_hit();
        read_hit(16'h0015, 32'hCAFE0001);
    endtask

    task automatic test_write();
        do_write(16'h0015, 32'h12345678, 32'hCAFE0001);
        read_hit(16'h0015, 32'h12345678);
        do_write(16'h0055, 32'hAAAA5555, 32'h12345678);
    endtask

    task automatic test_conflict();
        read_miss(16'h0055, 32'h0, 16'h0055, 32'hAAAA5555);
        read_miss(16'h0015, 32'h0, 16'h0015, 32'h12345678);
    endtask

    // Flush with a simultaneous read of a cached line: 64 flush cycles, then the read misses.
    task automatic test_flush();
        int bad = 0;
        FLUSH_I = 1'b1; PE_VALID_I = 1'b1; PE_WR_I = 1'b0; PE_BASE_I = 16'h0015; PE_OFFSET_I = '0;
        #1;
        checks++; if (STALL_O !== 1'b1) begin failures++; $display("FAIL fl_stall_start got=%0b exp=1", STALL_O); end
        tick();
        FLUSH_I = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (STALL_O !== 1'b1 || MEM_REQ_O !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL fl_busy_window bad_cycles=%0d exp=0", bad); end
        checks++; if (STALL_O !== 1'b1 || MEM_REQ_O !== 1'b0) begin failures++; $display("FAIL fl_idle_miss stall=%0b req=%0b exp=1/0", STALL_O, MEM_REQ_O); end
        tick();
        checks++; if (MEM_REQ_O !== 1'b1 || MEM_ADDR_O !== 16'h0015) begin failures++; $display("FAIL fl_req_after req=%0b addr=%h exp=1/0015", MEM_REQ_O, MEM_ADDR_O); end
        MEM_ACK_I = 1'b1; MEM_RDATA_I = 32'h12345678;
        tick();
        MEM_ACK_I = 1'b0; MEM_RDATA_I = '0;
        checks++; if (PE_DATA_O !== 32'h12345678 || STALL_O !== 1'b0) begin failures++; $display("FAIL fl_read_done data=%h stall=%0b exp=12345678/0", PE_DATA_O, STALL_O); end
        PE_VALID_I = 1'b0;
    endtask

    task automatic test_flush_pending();
        PE_VALID_I = 1'b1; PE_WR_I = 1'b0; PE_BASE_I = 16'h0055; PE_OFFSET_I = '0;
        tick();
        checks++; if (MEM_REQ_O !== 1'b1) begin failures++; $display("FAIL fp_req got=%0b exp=1", MEM_REQ_O); end
        FLUSH_I = 1'b1;
        tick();
        FLUSH_I = 1'b0;
        MEM_ACK_I = 1'b1; MEM_RDATA_I = 32'hAAAA5555;
        tick();
        MEM_ACK_I = 1'b0; MEM_RDATA_I = '0;
        checks++; if (PE_DATA_O !== 32'hAAAA5555 || MEM_REQ_O !== 1'b0) begin failures++; $display("FAIL fp_fill data=%h req=%0b exp=AAAA5555/0", PE_DATA_O, MEM_REQ_O); end
        checks++; if (STALL_O !== 1'b1) begin failures++; $display("FAIL fp_pending_stall got=%0b exp=1", STALL_O); end
        PE_VALID_I = 1'b0;
        repeat (64) tick();
        checks++; if (STALL_O !== 1'b1) begin failures++; $display("FAIL fp_flush_len_short got=%0b exp=1", STALL_O); end
        tick();
        checks++; if (STALL_O !== 1'b0) begin failures++; $display("FAIL fp_flush_end got=%0b exp=0", STALL_O); end
        read_miss(16'h0055, 32'h0, 16'h0055, 32'hAAAA5555);
    endtask

    task automatic test_wrap_and_reset();
        read_miss(16'hFFFE, 32'hABCD0003, 16'h0001, 32'h0BADF00D);
        PE_VALID_I = 1'b1; PE_WR_I = 1'b1; PE_BASE_I = 16'h0001; PE_OFFSET_I = '0; PE_WDATA_I = 32'h5A5A5A5A;
        tick();
        checks++; if (MEM_REQ_O !== 1'b1 || MEM_WR_O !== 1'b1) begin failures++; $display("FAIL rst_wr_req req=%0b wr=%0b exp=1/1", MEM_REQ_O, MEM_WR_O); end
        RST_I = 1'b1; PE_VALID_I = 1'b0; PE_WR_I = 1'b0;
        tick();
        RST_I = 1'b0;
        checks++; if (MEM_REQ_O !== 1'b0 || MEM_WR_O !== 1'b0) begin failures++; $display("FAIL rst_abort req=%0b wr=%0b exp=0/0", MEM_REQ_O, MEM_WR_O); end
        checks++; if (MEM_ADDR_O !== 16'h0 || MEM_WDATA_O !== 32'h0 || PE_DATA_O !== 32'h0) begin failures++; $display("FAIL rst_regs addr=%h wdata=%h pe=%h exp=0", MEM_ADDR_O, MEM_WDATA_O, PE_DATA_O); end
        MEM_ACK_I = 1'b1; MEM_RDATA_I = 32'hDEADBEEF;
        tick();
        MEM_ACK_I = 1'b0; MEM_RDATA_I = '0;
        checks++; if (MEM_REQ_O !== 1'b0 || STALL_O !== 1'b0 || PE_DATA_O !== 32'h0) begin failures++; $display("FAIL late_ack req=%0b stall=%0b pe=%h exp=0/0/0", MEM_REQ_O, STALL_O, PE_DATA_O); end
        read_miss(16'h0001, 32'h0, 16'h0001, 32'h0BADF00D);
    endtask

    initial begin
        RST_I = 1'b1; PE_VALID_I = 1'b0; PE_WR_I = 1'b0; PE_BASE_I = '0; PE_OFFSET_I = '0;
        PE_WDATA_I = '0; FLUSH_I = 1'b0; MEM_ACK_I = 1'b0; MEM_RDATA_I = '0;
        tick();
        tick();
        RST_I = 1'b0;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write();
        test_conflict();
        test_flush();
        test_flush_pending();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
